// File: rtl/board_pkg.sv
// Shared constants for the board control/status slice: FSM states, LED modes,
// parameter defaults and a counter-width helper.
package board_pkg;

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_DONE   = 2'b00;
  localparam logic [1:0] MODE_HB     = 2'b01;
  localparam logic [1:0] MODE_CNT_LO = 2'b10;
  localparam logic [1:0] MODE_CNT_HI = 2'b11;

  localparam int unsigned DEF_NUM_SW          = 4;
  localparam int unsigned DEF_NUM_LED         = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_RESET_HOLD      = 16;
  localparam int unsigned DEF_BLINK_DIV       = 50000000;
  localparam int unsigned DEF_CNT_WIDTH       = 32;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: 2-flop synchroniser followed by a stable
// counter that only lets a change through after DEBOUNCE_CYCLES steady cycles.
module sw_debounce
  import board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db
);

  localparam int unsigned CW = cnt_bits(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Counter restarts whenever the synchronised level agrees with the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/board_status_ctrl.sv
// Board control/status block: debounced switches, stretched core reset,
// run-cycle counter with sticky done, and switch-selected LED display.
module board_status_ctrl
  import board_pkg::*;
#(
  parameter int unsigned NUM_SW          = DEF_NUM_SW,
  parameter int unsigned NUM_LED         = DEF_NUM_LED,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RESET_HOLD      = DEF_RESET_HOLD,
  parameter int unsigned BLINK_DIV       = DEF_BLINK_DIV,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SW-1:0]    sw,
  input  logic                 core_done,
  output logic                 core_reset,
  output logic [NUM_LED-1:0]   led,
  output logic [NUM_SW-1:0]    sw_db,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 done_latched
);

  localparam int unsigned HW = cnt_bits(RESET_HOLD);
  localparam int unsigned PW = cnt_bits(BLINK_DIV);

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [HW-1:0]        hold_cnt;
  logic [HW-1:0]        hold_nxt;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic                 done_nxt;
  logic [PW-1:0]        pre;
  logic                 hb;
  logic [NUM_LED-1:0]   led_nxt;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .sw   (sw[i]),
      .db   (sw_db[i])
    );
  end

  // Next-state logic; a run/reset request always wins over core_done.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    count_nxt = cycle_count;
    done_nxt  = done_latched;
    case (state)
      ST_HOLD: begin
        count_nxt = '0;
        done_nxt  = 1'b0;
        if (sw_db[0]) begin
          hold_nxt = '0;
        end else if (hold_cnt == HW'(RESET_HOLD - 1)) begin
          state_nxt = ST_RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_RUN: begin
        if (sw_db[0]) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
          count_nxt = '0;
          done_nxt  = 1'b0;
        end else if (core_done) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else if (cycle_count != '1) begin
          count_nxt = cycle_count + CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (sw_db[0]) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
          count_nxt = '0;
          done_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    led_nxt = '0;
    case (sw_db[2:1])
      MODE_DONE:   led_nxt = {NUM_LED{done_latched}};
      MODE_HB: begin
        led_nxt    = {NUM_LED{done_latched}};
        led_nxt[0] = hb;
      end
      MODE_CNT_LO: led_nxt = cycle_count[NUM_LED-1:0];
      MODE_CNT_HI: led_nxt = cycle_count[CNT_WIDTH-1 -: NUM_LED];
      default:     led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_HOLD;
      hold_cnt     <= '0;
      cycle_count  <= '0;
      done_latched <= 1'b0;
      core_reset   <= 1'b1;
      led          <= '0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      cycle_count  <= count_nxt;
      done_latched <= done_nxt;
      core_reset   <= (state_nxt == ST_HOLD);
      led          <= led_nxt;
    end
  end

  // Free-running heartbeat, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre <= '0;
      hb  <= 1'b0;
    end else if (pre == PW'(BLINK_DIV - 1)) begin
      pre <= '0;
      hb  <= ~hb;
    end else begin
      pre <= pre + PW'(1);
    end
  end

endmodule

// File: tb/tb_board_status_ctrl.sv
// Bench for board_status_ctrl: directed vector table, heartbeat period check,
// and randomized stimulus against a cycle-level behavioural model.
module tb_board_status_ctrl;

  localparam int unsigned D    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned B    = 5;
  localparam int unsigned CW   = 8;
  localparam int unsigned NL   = 4;
  localparam int unsigned NS   = 4;
  localparam int          MAXC = 255;
  localparam int          P_HOLD = 0;
  localparam int          P_RUN  = 1;
  localparam int          P_DONE = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NS-1:0] sw;
  logic          core_done;
  logic          core_reset;
  logic [NL-1:0] led;
  logic [NS-1:0] sw_db;
  logic [CW-1:0] cycle_count;
  logic          done_latched;

  always #5 clk = ~clk;

  board_status_ctrl #(
    .NUM_SW(NS), .NUM_LED(NL), .DEBOUNCE_CYCLES(D),
    .RESET_HOLD(H), .BLINK_DIV(B), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .core_done(core_done),
    .core_reset(core_reset), .led(led), .sw_db(sw_db),
    .cycle_count(cycle_count), .done_latched(done_latched)
  );

  typedef struct {
    bit       rst;
    logic [3:0] sw;
    bit       done;
    int       cyc;
    bit       cr;
    logic [7:0] cnt;
    bit       dl;
    logic [3:0] led;
    logic [3:0] db;
  } vec_t;

  vec_t vecs[21];
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [3:0] m_d1, m_d2, m_db, m_led;
  logic [3:0] hist[$];
  int m_phase, m_age, m_count, m_edges;
  bit m_done, m_cr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rst, logic [3:0] s, bit dn, int cyc, bit cr,
                              logic [7:0] cnt, bit dl, logic [3:0] l, logic [3:0] db);
    vec_t v;
    v.rst = rst; v.sw = s; v.done = dn; v.cyc = cyc; v.cr = cr;
    v.cnt = cnt; v.dl = dl; v.led = l; v.db = db;
    return v;
  endfunction

  task automatic go_hold();
    m_phase = P_HOLD; m_age = 0; m_count = 0; m_done = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using pre-edge values.
  task automatic model_step();
    logic [3:0] o_db, syn;
    int o_count, o_phase;
    bit o_done, o_hb, all_diff;
    if (!reset) begin
      m_d1 = '0; m_d2 = '0; m_db = '0; m_led = '0;
      hist.delete();
      for (int k = 0; k < int'(D); k++) hist.push_back(4'b0);
      go_hold();
      m_edges = 0; m_cr = 1'b1;
    end else begin
      o_db = m_db; o_count = m_count; o_phase = m_phase; o_done = m_done;
      o_hb = ((m_edges / int'(B)) % 2) == 1;
      case (o_db[2:1])
        2'b00:   m_led = {4{o_done}};
        2'b01:   m_led = {{3{o_done}}, o_hb};
        2'b10:   m_led = 4'(o_count % 16);
        default: m_led = 4'((o_count / 16) % 16);
      endcase
      syn = m_d2; m_d2 = m_d1; m_d1 = sw;
      hist.push_back(syn);
      void'(hist.pop_front());
      for (int i = 0; i < int'(NS); i++) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k][i] == o_db[i]) all_diff = 1'b0;
        if (all_diff) m_db[i] = ~o_db[i];
      end
      case (o_phase)
        P_HOLD: begin
          m_age = o_db[0] ? 0 : m_age + 1;
          if (m_age == int'(H)) begin m_phase = P_RUN; m_age = 0; end
        end
        P_RUN: begin
          if (o_db[0]) go_hold();
          else if (core_done) begin m_phase = P_DONE; m_done = 1'b1; end
          else m_count = (o_count + 1 > MAXC) ? MAXC : o_count + 1;
        end
        default: if (o_db[0]) go_hold();
      endcase
      m_cr = (m_phase == P_HOLD);
      m_edges++;
    end
  endtask

  // Advance one clock, update the model, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (chk_en) begin
      check("m_core_reset", 32'(core_reset), 32'(m_cr));
      check("m_cycle_count", 32'(cycle_count), 32'(m_count));
      check("m_done_latched", 32'(done_latched), 32'(m_done));
      check("m_led", 32'(led), 32'(m_led));
      check("m_sw_db", 32'(sw_db), 32'(m_db));
    end
  endtask

  initial begin
    int last_t, ntog, t;
    logic prev;
    vecs[0]  = mk(0, 4'b0000, 0,   3, 1, 8'd0,   0, 4'b0000, 4'b0000);
    vecs[1]  = mk(1, 4'b0000, 0,   2, 1, 8'd0,   0, 4'b0000, 4'b0000);
    vecs[2]  = mk(1, 4'b0000, 0,   1, 0, 8'd0,   0, 4'b0000, 4'b0000);
    vecs[3]  = mk(1, 4'b0100, 0,   6, 0, 8'd6,   0, 4'b0000, 4'b0100);
    vecs[4]  = mk(1, 4'b0100, 0,  14, 0, 8'd20,  0, 4'b0011, 4'b0100);
    vecs[5]  = mk(1, 4'b0100, 1,   1, 0, 8'd20,  1, 4'b0100, 4'b0100);
    vecs[6]  = mk(1, 4'b0100, 1,  10, 0, 8'd20,  1, 4'b0100, 4'b0100);
    vecs[7]  = mk(1, 4'b0110, 0,   3, 0, 8'd20,  1, 4'b0100, 4'b0100);
    vecs[8]  = mk(1, 4'b0100, 0,   6, 0, 8'd20,  1, 4'b0100, 4'b0100);
    vecs[9]  = mk(1, 4'b0110, 0,   5, 0, 8'd20,  1, 4'b0100, 4'b0100);
    vecs[10] = mk(1, 4'b0110, 0,   1, 0, 8'd20,  1, 4'b0100, 4'b0110);
    vecs[11] = mk(1, 4'b0110, 0,   1, 0, 8'd20,  1, 4'b0001, 4'b0110);
    vecs[12] = mk(1, 4'b0111, 0,   6, 0, 8'd20,  1, 4'b0001, 4'b0111);
    vecs[13] = mk(1, 4'b0111, 0,   1, 1, 8'd0,   0, 4'b0001, 4'b0111);
    vecs[14] = mk(1, 4'b0111, 0,   1, 1, 8'd0,   0, 4'b0000, 4'b0111);
    vecs[15] = mk(1, 4'b0110, 0,   6, 1, 8'd0,   0, 4'b0000, 4'b0110);
    vecs[16] = mk(1, 4'b0110, 0,   2, 1, 8'd0,   0, 4'b0000, 4'b0110);
    vecs[17] = mk(1, 4'b0110, 0,   1, 0, 8'd0,   0, 4'b0000, 4'b0110);
    vecs[18] = mk(1, 4'b0110, 0, 300, 0, 8'd255, 0, 4'b1111, 4'b0110);
    vecs[19] = mk(1, 4'b0111, 0,   6, 0, 8'd255, 0, 4'b1111, 4'b0111);
    vecs[20] = mk(1, 4'b0111, 1,   1, 1, 8'd0,   0, 4'b1111, 4'b0111);

    reset = 1'b0; sw = '0; core_done = 1'b0;
    cycle();
    chk_en = 1'b1;

    foreach (vecs[v]) begin
      reset = vecs[v].rst; sw = vecs[v].sw; core_done = vecs[v].done;
      repeat (vecs[v].cyc) cycle();
      check($sformatf("vec%0d core_reset", v), 32'(core_reset), 32'(vecs[v].cr));
      check($sformatf("vec%0d cycle_count", v), 32'(cycle_count), 32'(vecs[v].cnt));
      check($sformatf("vec%0d done_latched", v), 32'(done_latched), 32'(vecs[v].dl));
      check($sformatf("vec%0d led", v), 32'(led), 32'(vecs[v].led));
      check($sformatf("vec%0d sw_db", v), 32'(sw_db), 32'(vecs[v].db));
    end

    // Heartbeat mode while held: led[0] must toggle every B cycles.
    sw = 4'b0011; core_done = 1'b0;
    repeat (8) cycle();
    prev = led[0]; last_t = -1; ntog = 0;
    for (t = 0; t < 32; t++) begin
      cycle();
      if (led[0] !== prev) begin
        if (last_t >= 0) check("hb_period", 32'(t - last_t), 32'(B));
        last_t = t; ntog++; prev = led[0];
      end
    end
    check("hb_toggles", 32'(ntog >= 5), 32'd1);

    // Randomized phase: slow-moving switches, sporadic done and resets.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < int'(NS); i++)
        if ($urandom_range(0, 11) == 0) sw[i] = ~sw[i];
      core_done = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
